// File: rtl/maxpool_row_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// maxpool_row_scheduler_pkg : shared sizes and FSM encoding for the maxpool
// row scheduler.                                        Revision: 1.0
// ============================================================================
package maxpool_row_scheduler_pkg;

    localparam int IMG_WIDTH  = 8;
    localparam int TIME_STEPS = 4;
    localparam int DIM_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_MP = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_EMIT    = 3'd5,
        ST_NEXT    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxpool_row_scheduler_vert_accum.sv
`default_nettype none
// ============================================================================
// maxpool_vert_accum : vertical 3-tap / stride-2 OR reduction over pooled rows.
//                                                       Revision: 1.0
// ============================================================================
module maxpool_vert_accum
    import maxpool_row_scheduler_pkg::*;
#(
    parameter int HP_W = (IMG_WIDTH / 2) * TIME_STEPS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic            odd_i,
    input  logic [HP_W-1:0] hp_i,
    output logic [HP_W-1:0] out_o
);

    logic [HP_W-1:0] acc_q, acc_d;
    logic [HP_W-1:0] carry_q, carry_d;
    logic [HP_W-1:0] out_q, out_d;

    // Even row opens a window seeded with the shared carry row; odd row
    // closes it and becomes the carry for the next window.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        out_d   = out_q;
        if (clear_i) begin
            acc_d   = '0;
            carry_d = '0;
        end else if (en_i) begin
            if (odd_i) begin
                out_d   = acc_q | hp_i;
                carry_d = hp_i;
            end else begin
                acc_d = carry_q | hp_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            carry_q <= '0;
            out_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            out_q   <= out_d;
        end
    end

    assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/maxpool_row_scheduler.sv
`default_nettype none
// ============================================================================
// maxpool_row_scheduler : walks a spike feature map row by row through the
// horizontal row unit and emits vertically pooled rows.  Revision: 1.0
// ============================================================================
module maxpool_row_scheduler
    import maxpool_row_scheduler_pkg::*;
#(
    parameter int IMG_W = IMG_WIDTH,
    parameter int T     = TIME_STEPS,
    parameter int DIM_W = DIM_WIDTH
) (
    input  logic               s_clk,
    input  logic               s_rst_n,
    input  logic               code_valid,
    input  logic [DIM_W-1:0]   conv_in_ch,
    input  logic [DIM_W-1:0]   conv_img_size,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err,
    output logic               o_rd_req,
    output logic [DIM_W-1:0]   o_rd_ch,
    output logic [DIM_W-1:0]   o_rd_row,
    input  logic               i_rd_valid,
    input  logic [IMG_W*T-1:0] i_rd_data,
    output logic               o_mp_code_valid,
    output logic [DIM_W-1:0]   o_mp_img_size,
    output logic               o_mp_row_valid,
    output logic [IMG_W*T-1:0] o_mp_row_data,
    input  logic               i_mp_busy,
    input  logic               i_mp_valid,
    input  logic [IMG_W*T-1:0] i_mp_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [IMG_W*T-1:0] o_out_data,
    output logic [DIM_W-1:0]   o_out_ch,
    output logic [DIM_W-1:0]   o_out_row
);

    localparam int DATA_W = IMG_W * T;
    localparam int HP_W   = (IMG_W / 2) * T;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    ch_q, ch_d;
    logic [DIM_W-1:0]    row_q, row_d;
    logic [DIM_W-1:0]    size_q, size_d;
    logic [DIM_W-1:0]    chans_q, chans_d;
    logic                cfg_err_q, cfg_err_d;
    logic                mp_cfg_q, mp_cfg_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [HP_W-1:0]     hp_q, hp_d;

    logic                cfg_legal;
    logic                start_ok;
    logic                last_row;
    logic                last_ch;
    logic                acc_clear;
    logic                acc_en;
    logic [DIM_W-1:0]    hp_lim;
    logic [HP_W-1:0]     hp_mask;
    logic [HP_W-1:0]     acc_out;
    logic                unused_mp_hi;

    assign cfg_legal = !conv_img_size[0]
                     && (conv_img_size >= DIM_W'(4))
                     && (conv_img_size <= DIM_W'(2 * IMG_W))
                     && (conv_in_ch != '0);

    // Only legal sizes are ever latched, so a nonzero size means "configured".
    assign start_ok = (state_q == ST_IDLE) && i_start && !cfg_err_q && (size_q != '0);
    assign last_row = (row_q == size_q - DIM_W'(1));
    assign last_ch  = (ch_q == chans_q - DIM_W'(1));

    // Columns past H/2 carry no pooled data and are forced to zero.
    assign hp_lim = (size_q >> 1) * DIM_W'(T);

    always_comb begin
        hp_mask = '0;
        for (int i = 0; i < HP_W; i++) begin
            hp_mask[i] = (DIM_W'(i) < hp_lim);
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        row_d     = row_q;
        size_d    = size_q;
        chans_d   = chans_q;
        cfg_err_d = cfg_err_q;
        mp_cfg_d  = 1'b0;
        rdata_d   = rdata_q;
        hp_d      = hp_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (code_valid) begin
                    if (cfg_legal) begin
                        size_d    = conv_img_size;
                        chans_d   = conv_in_ch;
                        cfg_err_d = 1'b0;
                        mp_cfg_d  = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (start_ok) begin
                    ch_d      = '0;
                    row_d     = '0;
                    acc_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_rd_valid) begin
                    rdata_d = i_rd_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_mp_busy) begin
                    state_d = ST_WAIT_MP;
                end
            end
            ST_WAIT_MP: begin
                if (i_mp_valid) begin
                    hp_d    = i_mp_data[HP_W-1:0] & hp_mask;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_en  = 1'b1;
                state_d = row_q[0] ? ST_EMIT : ST_NEXT;
            end
            ST_EMIT: begin
                if (i_out_ready) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!last_row) begin
                    row_d   = row_q + DIM_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    // Channel boundary: the carry row must not reach the next channel.
                    row_d     = '0;
                    acc_clear = 1'b1;
                    if (last_ch) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d    = ch_q + DIM_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            row_q     <= '0;
            size_q    <= '0;
            chans_q   <= '0;
            cfg_err_q <= 1'b0;
            mp_cfg_q  <= 1'b0;
            rdata_q   <= '0;
            hp_q      <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
            size_q    <= size_d;
            chans_q   <= chans_d;
            cfg_err_q <= cfg_err_d;
            mp_cfg_q  <= mp_cfg_d;
            rdata_q   <= rdata_d;
            hp_q      <= hp_d;
        end
    end

    maxpool_vert_accum #(
        .HP_W (HP_W)
    ) u_vert_accum (
        .clk_i   (s_clk),
        .rst_ni  (s_rst_n),
        .clear_i (acc_clear),
        .en_i    (acc_en),
        .odd_i   (row_q[0]),
        .hp_i    (hp_q),
        .out_o   (acc_out)
    );

    assign unused_mp_hi    = ^i_mp_data[DATA_W-1:HP_W];

    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_NEXT) && last_row && last_ch;
    assign o_cfg_err       = cfg_err_q;
    assign o_rd_req        = (state_q == ST_FETCH);
    assign o_rd_ch         = ch_q;
    assign o_rd_row        = row_q;
    assign o_mp_code_valid = mp_cfg_q;
    assign o_mp_img_size   = size_q;
    assign o_mp_row_valid  = (state_q == ST_ISSUE) && !i_mp_busy;
    assign o_mp_row_data   = rdata_q;
    assign o_out_valid     = (state_q == ST_EMIT);
    assign o_out_data      = {{(DATA_W - HP_W){1'b0}}, acc_out};
    assign o_out_ch        = ch_q;
    assign o_out_row       = row_q >> 1;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_row_scheduler.sv
`default_nettype none
// ============================================================================
// tb_maxpool_row_scheduler : randomized bench with a behavioural pooling model.
//                                                       Revision: 1.0
// ============================================================================
module tb_maxpool_row_scheduler;
    import maxpool_row_scheduler_pkg::*;

    localparam int IMG_W  = IMG_WIDTH;
    localparam int T      = TIME_STEPS;
    localparam int DIM_W  = DIM_WIDTH;
    localparam int DATA_W = IMG_W * T;
    localparam int HP_W   = (IMG_W / 2) * T;
    localparam int MAX_H  = 2 * IMG_W;
    localparam int MAX_C  = 3;

    logic               s_clk;
    logic               s_rst_n;
    logic               code_valid;
    logic [DIM_W-1:0]   conv_in_ch;
    logic [DIM_W-1:0]   conv_img_size;
    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic               o_cfg_err;
    logic               o_rd_req;
    logic [DIM_W-1:0]   o_rd_ch;
    logic [DIM_W-1:0]   o_rd_row;
    logic               i_rd_valid;
    logic [DATA_W-1:0]  i_rd_data;
    logic               o_mp_code_valid;
    logic [DIM_W-1:0]   o_mp_img_size;
    logic               o_mp_row_valid;
    logic [DATA_W-1:0]  o_mp_row_data;
    logic               i_mp_busy;
    logic               i_mp_valid;
    logic [DATA_W-1:0]  i_mp_data;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [DATA_W-1:0]  o_out_data;
    logic [DIM_W-1:0]   o_out_ch;
    logic [DIM_W-1:0]   o_out_row;

    maxpool_row_scheduler dut (
        .s_clk           (s_clk),
        .s_rst_n         (s_rst_n),
        .code_valid      (code_valid),
        .conv_in_ch      (conv_in_ch),
        .conv_img_size   (conv_img_size),
        .i_start         (i_start),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_cfg_err       (o_cfg_err),
        .o_rd_req        (o_rd_req),
        .o_rd_ch         (o_rd_ch),
        .o_rd_row        (o_rd_row),
        .i_rd_valid      (i_rd_valid),
        .i_rd_data       (i_rd_data),
        .o_mp_code_valid (o_mp_code_valid),
        .o_mp_img_size   (o_mp_img_size),
        .o_mp_row_valid  (o_mp_row_valid),
        .o_mp_row_data   (o_mp_row_data),
        .i_mp_busy       (i_mp_busy),
        .i_mp_valid      (i_mp_valid),
        .i_mp_data       (i_mp_data),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_data      (o_out_data),
        .o_out_ch        (o_out_ch),
        .o_out_row       (o_out_row)
    );

    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference data: pooled row the row unit returns for each (channel,row),
    // and the output rows expected from 3-tap/stride-2/top-pad OR pooling.
    typedef struct {
        int              ch;
        int              row;
        logic [HP_W-1:0] data;
    } exp_t;

    logic [HP_W-1:0] hp_tab [MAX_C][MAX_H];
    exp_t            exp_q[$];

    bit              rd_en    = 1'b1;
    bit              rdy_rand = 1'b1;
    bit              expect_done = 1'b0;
    int              run_h = 1;
    int              rd_idx, n_reads, n_issues, n_outs, n_done, n_mpcfg;
    int              last_ch, last_row;
    logic [DATA_W-1:0] last_rd;
    logic [DIM_W-1:0]  mpcfg_size;

    task automatic fill_random();
        logic [63:0] r64;
        for (int c = 0; c < MAX_C; c++) begin
            for (int r = 0; r < MAX_H; r++) begin
                r64 = {$urandom, $urandom};
                hp_tab[c][r] = r64[HP_W-1:0];
            end
        end
    endtask

    task automatic build_exp(input int h, input int c);
        exp_t            e;
        logic [HP_W-1:0] v;
        int              lim;
        exp_q.delete();
        lim = (h / 2) * T;
        for (int ch = 0; ch < c; ch++) begin
            for (int r = 0; r < h / 2; r++) begin
                v = hp_tab[ch][2*r] | hp_tab[ch][2*r+1];
                if (r > 0) v = v | hp_tab[ch][2*r-1];
                for (int b = 0; b < HP_W; b++) begin
                    if (b >= lim) v[b] = 1'b0;
                end
                e.ch = ch; e.row = r; e.data = v;
                exp_q.push_back(e);
            end
        end
    endtask

    // Ifmap row buffer: answers each request after 0..2 extra cycles.
    initial begin
        logic [63:0] r64;
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
        forever begin
            @(negedge s_clk);
            if (rd_en) begin
                i_rd_valid = 1'b0;
                if (o_rd_req) begin
                    repeat ($urandom_range(0, 2)) @(negedge s_clk);
                    if (o_rd_req && rd_en) begin
                        check("rd_ch", 64'(o_rd_ch), 64'(rd_idx / run_h));
                        check("rd_row", 64'(o_rd_row), 64'(rd_idx % run_h));
                        last_ch  = int'(o_rd_ch);
                        last_row = int'(o_rd_row);
                        r64      = {$urandom, $urandom};
                        last_rd  = r64[DATA_W-1:0];
                        i_rd_data  = last_rd;
                        i_rd_valid = 1'b1;
                        rd_idx++;
                        n_reads++;
                    end
                end
            end
        end
    end

    // Horizontal row unit: returns the tabulated pooled row 1..4 cycles later.
    initial begin
        logic [63:0]       r64;
        logic [DATA_W-1:0] tmp;
        int                pc, pr;
        i_mp_valid = 1'b0;
        i_mp_data  = '0;
        forever begin
            @(negedge s_clk);
            i_mp_valid = 1'b0;
            if (o_mp_row_valid) begin
                check("issue_data", 64'(o_mp_row_data), 64'(last_rd));
                n_issues++;
                pc = last_ch;
                pr = last_row;
                repeat ($urandom_range(1, 4)) @(negedge s_clk);
                r64 = {$urandom, $urandom};
                tmp = r64[DATA_W-1:0];
                tmp[HP_W-1:0] = hp_tab[pc][pr];
                i_mp_data  = tmp;
                i_mp_valid = 1'b1;
            end
        end
    end

    // Output sink and scoreboard.
    initial begin
        exp_t              e;
        logic [DATA_W-1:0] ev;
        i_out_ready = 1'b0;
        forever begin
            @(negedge s_clk);
            if (o_mp_code_valid) begin
                n_mpcfg++;
                mpcfg_size = o_mp_img_size;
            end
            if (expect_done) begin
                check("done_timing", 64'(o_done), 64'(1));
                expect_done = 1'b0;
            end
            if (o_done) n_done++;
            if (rdy_rand) i_out_ready = ($urandom_range(0, 3) != 0);
            if (o_out_valid && i_out_ready) begin
                n_outs++;
                if (exp_q.size() == 0) begin
                    check("extra_out", 64'(o_out_valid), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ev = '0;
                    ev[HP_W-1:0] = e.data;
                    check("out_data", 64'(o_out_data), 64'(ev));
                    check("out_ch", 64'(o_out_ch), 64'(e.ch));
                    check("out_row", 64'(o_out_row), 64'(e.row));
                    if (exp_q.size() == 0) expect_done = 1'b1;
                end
            end
        end
    end

    task automatic configure(input int size, input int ch);
        @(posedge s_clk); #1;
        conv_img_size = DIM_W'(size);
        conv_in_ch    = DIM_W'(ch);
        code_valid    = 1'b1;
        @(posedge s_clk); #1;
        code_valid    = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge s_clk); #1;
        i_start = 1'b1;
        @(posedge s_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run(input int h, input int c, input int budget);
        int cyc;
        run_h = h; rd_idx = 0; n_reads = 0; n_issues = 0; n_outs = 0; n_done = 0;
        build_exp(h, c);
        configure(h, c);
        @(posedge s_clk); #1;
        i_start = 1'b1;
        @(posedge s_clk); #1;
        i_start = 1'b0;
        check("busy_after_start", 64'(o_busy), 64'(1));
        cyc = 0;
        while (n_done == 0 && cyc < budget) begin
            @(posedge s_clk);
            cyc++;
        end
        repeat (3) @(posedge s_clk);
        check("run_in_budget", 64'(cyc < budget), 64'(1));
        check("reads", 64'(n_reads), 64'(h * c));
        check("issues", 64'(n_issues), 64'(h * c));
        check("outs", 64'(n_outs), 64'((h / 2) * c));
        check("done_count", 64'(n_done), 64'(1));
        check("exp_left", 64'(exp_q.size()), 64'(0));
        check("busy_end", 64'(o_busy), 64'(0));
    endtask

    initial begin
        bit   seen;
        int   cnt, changes;
        logic [DATA_W-1:0] cap_data;
        logic [DIM_W-1:0]  cap_row, cap_ch;

        s_rst_n = 1'b0; code_valid = 1'b0; conv_in_ch = '0; conv_img_size = '0;
        i_start = 1'b0; i_mp_busy = 1'b0;
        repeat (3) @(posedge s_clk);
        #1 s_rst_n = 1'b1;
        @(negedge s_clk);
        check("rst_ctrl", 64'({o_busy, o_done, o_cfg_err, o_rd_req, o_mp_code_valid,
                               o_mp_row_valid, o_out_valid}), 64'(0));
        check("rst_idx", 64'({o_rd_ch, o_rd_row, o_out_ch}), 64'(0));
        check("rst_size_row", 64'({o_mp_img_size, o_out_row}), 64'(0));
        check("rst_data", 64'({o_mp_row_data, o_out_data}), 64'(0));

        // Illegal configurations, including range boundaries.
        n_mpcfg = 0;
        configure(5, 1);
        @(negedge s_clk);
        check("cfg_err_odd", 64'(o_cfg_err), 64'(1));
        pulse_start();
        seen = 1'b0;
        repeat (4) begin @(negedge s_clk); seen |= o_busy; end
        check("start_ignored_err", 64'(seen), 64'(0));
        configure(8, 0);
        @(negedge s_clk);
        check("cfg_err_ch0", 64'(o_cfg_err), 64'(1));
        configure(2, 1);
        @(negedge s_clk);
        check("cfg_err_small", 64'(o_cfg_err), 64'(1));
        configure(MAX_H + 2, 1);
        @(negedge s_clk);
        check("cfg_err_large", 64'(o_cfg_err), 64'(1));
        configure(8, 1);
        repeat (2) @(negedge s_clk);
        check("cfg_err_clear", 64'(o_cfg_err), 64'(0));
        check("mp_cfg_pulses", 64'(n_mpcfg), 64'(1));
        check("mp_cfg_size", 64'(mpcfg_size), 64'(8));
        check("mp_img_size", 64'(o_mp_img_size), 64'(8));

        // Reset while a read is outstanding, then a late read valid.
        rd_en = 1'b0; i_rd_valid = 1'b0; run_h = 4;
        configure(4, 1);
        pulse_start();
        cnt = 0;
        while (!o_rd_req && cnt < 20) begin @(negedge s_clk); cnt++; end
        check("fetch_req", 64'(o_rd_req), 64'(1));
        @(posedge s_clk); #1;
        s_rst_n = 1'b0; i_rd_valid = 1'b1; i_rd_data = '1;
        @(posedge s_clk); #1;
        s_rst_n = 1'b1; i_start = 1'b1;
        @(posedge s_clk); #1;
        i_rd_valid = 1'b0; i_start = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge s_clk);
            seen |= o_mp_row_valid | o_out_valid | o_busy | o_rd_req;
        end
        check("rst_quiet", 64'(seen), 64'(0));
        check("rst_row_data", 64'(o_mp_row_data), 64'(0));
        check("rst_cfg_size", 64'(o_mp_img_size), 64'(0));
        rd_en = 1'b1;

        // Single channel with the documented one-hot rows.
        fill_random();
        hp_tab[0][0] = HP_W'(1); hp_tab[0][1] = HP_W'(2);
        hp_tab[0][2] = HP_W'(4); hp_tab[0][3] = HP_W'(8);
        run(4, 1, 1000);

        // Carry isolation between channels.
        fill_random();
        hp_tab[0][3] = '1;
        for (int r = 0; r < MAX_H; r++) hp_tab[1][r] = '0;
        run(4, 2, 2000);

        // Output backpressure for 10 cycles.
        fill_random();
        rdy_rand = 1'b0; i_out_ready = 1'b0;
        fork
            run(4, 1, 1000);
            begin
                cnt = 0;
                while (!o_out_valid && cnt < 500) begin @(negedge s_clk); cnt++; end
                check("bp_valid_seen", 64'(o_out_valid), 64'(1));
                cap_data = o_out_data; cap_row = o_out_row; cap_ch = o_out_ch;
                changes = 0; seen = 1'b0;
                repeat (10) begin
                    @(negedge s_clk);
                    if (o_out_data !== cap_data || o_out_row !== cap_row || o_out_ch !== cap_ch)
                        changes++;
                    seen |= o_rd_req;
                end
                check("bp_stable", 64'(changes), 64'(0));
                check("bp_no_rdreq", 64'(seen), 64'(0));
                check("bp_valid_held", 64'(o_out_valid), 64'(1));
                @(posedge s_clk); #1;
                i_out_ready = 1'b1;
            end
        join
        rdy_rand = 1'b1;

        // Row unit busy during ISSUE.
        fill_random();
        i_mp_busy = 1'b1;
        fork
            run(4, 1, 1000);
            begin
                cnt = 0;
                while (!o_rd_req && cnt < 100) begin @(negedge s_clk); cnt++; end
                while (o_rd_req && cnt < 200) begin @(negedge s_clk); cnt++; end
                check("busy_in_issue", 64'(o_busy && !o_rd_req), 64'(1));
                cnt = 0;
                repeat (5) begin @(negedge s_clk); if (o_mp_row_valid) cnt++; end
                check("issue_deferred", 64'(cnt), 64'(0));
                @(posedge s_clk); #1;
                i_mp_busy = 1'b0;
                cnt = 0;
                repeat (4) begin @(negedge s_clk); if (o_mp_row_valid) cnt++; end
                check("issue_one_cycle", 64'(cnt), 64'(1));
            end
        join

        // Mid size and full size with random data and random ready.
        fill_random();
        run(8, 2, 3000);
        fill_random();
        run(MAX_H, 3, 8000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
